// File: rtl/npu_pkg.sv
// Shared NPU definitions: bias loader FSM state encodings.
package npu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } bl_state_e;

endpackage

// File: rtl/onehot_dec.sv
// Binary lane index to one-hot write enable, gated by a write strobe.
module onehot_dec #(
  parameter int ARRAY_N = 16
) (
  input  logic [$clog2(ARRAY_N):0] index_i,
  input  logic                     strobe_i,
  output logic [ARRAY_N-1:0]       onehot_o
);

  localparam int IW = $clog2(ARRAY_N) + 1;

  // Out-of-range indices decode to no enable at all.
  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < ARRAY_N; i++) begin
      onehot_o[i] = strobe_i && (index_i == IW'(i));
    end
  end

endmodule

// File: rtl/bias_loader.sv
// Streams bias words into SIMD lane registers, one lane per handshake.
// Optional BIAS_LOADER_ZERO_FILL_EN adds a FILL state zeroing unloaded lanes.
module bias_loader
  import npu_pkg::*;
#(
  parameter int ARRAY_N   = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [$clog2(ARRAY_N):0] num_bias,
  input  logic                     s_valid,
  input  logic [OUT_WIDTH-1:0]     s_data,
  output logic                     s_ready,
  output logic [$clog2(ARRAY_N):0] w_index,
  output logic [OUT_WIDTH-1:0]     w_data,
  output logic [ARRAY_N-1:0]       w_en,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(ARRAY_N) + 1;
  localparam logic [IW-1:0] LaneMax = IW'(ARRAY_N);

`ifdef BIAS_LOADER_ZERO_FILL_EN
  localparam bit ZeroFill = 1'b1;
`else
  localparam bit ZeroFill = 1'b0;
`endif

  bl_state_e            state_q, state_d;
  logic [IW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        lane_q;
  logic [IW-1:0]        widx_q;
  logic [OUT_WIDTH-1:0] wdata_q;
  logic                 wr_q;
  logic                 s_ready_q, busy_q, done_q;
  logic                 hs;

  assign hs    = s_valid & s_ready_q;
  assign cnt_d = (num_bias > LaneMax) ? LaneMax : num_bias;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cnt_d != '0) state_d = ST_LOAD;
          else             state_d = ZeroFill ? ST_FILL : ST_DONE;
        end
      end
      ST_LOAD: begin
        if (hs && (lane_q == cnt_q - IW'(1))) begin
          state_d = (ZeroFill && (cnt_q < LaneMax)) ? ST_FILL : ST_DONE;
        end
      end
`ifdef BIAS_LOADER_ZERO_FILL_EN
      ST_FILL: begin
        if (lane_q == IW'(ARRAY_N - 1)) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      lane_q    <= '0;
      widx_q    <= '0;
      wdata_q   <= '0;
      wr_q      <= 1'b0;
      s_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= (state_d == ST_LOAD);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= (state_d == ST_DONE);
      wr_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q  <= cnt_d;
            lane_q <= '0;
          end
        end
        ST_LOAD: begin
          if (hs) begin
            wr_q    <= 1'b1;
            widx_q  <= lane_q;
            wdata_q <= s_data;
            lane_q  <= lane_q + IW'(1);
          end
        end
`ifdef BIAS_LOADER_ZERO_FILL_EN
        ST_FILL: begin
          wr_q    <= 1'b1;
          widx_q  <= lane_q;
          wdata_q <= '0;
          lane_q  <= lane_q + IW'(1);
        end
`endif
        default: ;
      endcase
    end
  end

  onehot_dec #(
    .ARRAY_N(ARRAY_N)
  ) u_dec (
    .index_i (widx_q),
    .strobe_i(wr_q),
    .onehot_o(w_en)
  );

  assign s_ready = s_ready_q;
  assign w_index = widx_q;
  assign w_data  = wdata_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: vector table, corner sequences, random loads.
module tb_bias_loader;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int IW = 5;

`ifdef BIAS_LOADER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, s_valid;
  logic [IW-1:0] num_bias;
  logic [W-1:0]  s_data;
  logic          s_ready, busy, done;
  logic [IW-1:0] w_index;
  logic [W-1:0]  w_data;
  logic [N-1:0]  w_en;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] ref_lane [N];
  logic [W-1:0] obs_lane [N];

  typedef struct {
    int num;
    int vmode;
    bit seq;
    int exp_wr;
    int exp_done;
  } vec_t;

  vec_t tbl [6];

  bias_loader #(.ARRAY_N(N), .OUT_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .num_bias(num_bias),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_index(w_index), .w_data(w_data), .w_en(w_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_lanes();
    for (int i = 0; i < N; i++) chk($sformatf("lane%0d", i), 64'(obs_lane[i]), 64'(ref_lane[i]));
  endtask

  // One complete load. Reference: lanes 0..cnt-1 take the streamed words in order,
  // each write one cycle after its handshake; zero-fill writes follow back-to-back;
  // done coincides with the last write (or cycle 1 for an empty load).
  task automatic run_load(input int num, input int vmode, input bit seq, input bit ghost,
                          output int n_wr, output int d_cyc);
    int cnt, sent, h_last, exp_done, prev_lane;
    bit prev_hs, vld, exp_ready, exp_wr, hs, ended;
    logic [W-1:0]  words [N];
    logic [IW-1:0] exp_idx;
    logic [W-1:0]  exp_dat;
    logic [N-1:0]  exp_en;
    cnt = (num > N) ? N : num;
    for (int i = 0; i < N; i++) words[i] = seq ? W'(i + 1) : $urandom;
    for (int i = 0; i < N; i++) begin
      if (i < cnt) ref_lane[i] = words[i];
      else if (ZF) ref_lane[i] = '0;
    end
    @(negedge clk);
    start = 1'b1; num_bias = IW'(num); s_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    sent = 0; prev_hs = 0; prev_lane = 0; n_wr = 0; d_cyc = -1; ended = 0;
    h_last   = (cnt == 0) ? 0 : -1;
    exp_done = (cnt == 0) ? (ZF ? N + 1 : 1) : -1;
    for (int k = 1; k <= 400 && !ended; k++) begin
      exp_ready = (sent < cnt);
      exp_wr = 0; exp_idx = '0; exp_dat = '0;
      if (prev_hs) begin
        exp_wr = 1; exp_idx = IW'(prev_lane); exp_dat = words[prev_lane];
      end else if (ZF && h_last >= 0 && k >= h_last + 2 && k <= h_last + 1 + N - cnt) begin
        exp_wr = 1; exp_idx = IW'(cnt + k - h_last - 2);
      end
      exp_en = exp_wr ? (N'(1) << exp_idx) : '0;
      chk("s_ready", 64'(s_ready), 64'(exp_ready));
      chk("busy", 64'(busy), 64'(exp_done < 0 || k <= exp_done));
      chk("done", 64'(done), 64'(k == exp_done));
      chk("w_en", 64'(w_en), 64'(exp_en));
      if (exp_wr) begin
        chk("w_index", 64'(w_index), 64'(exp_idx));
        chk("w_data", 64'(w_data), 64'(exp_dat));
      end
      if (w_en != '0) begin
        n_wr++;
        if (w_index < IW'(N)) obs_lane[w_index[3:0]] = w_data;
      end
      if (done) d_cyc = k;
      if (exp_done >= 0 && k > exp_done) begin
        ended = 1;
      end else begin
        case (vmode)
          0:       vld = 1'b1;
          1:       vld = (k % 2) == 1;
          default: vld = ($urandom_range(0, 99) < 65);
        endcase
        s_valid  = vld;
        s_data   = (vld && sent < cnt) ? words[sent] : $urandom;
        start    = ghost && (k == 2 || k == 3);
        num_bias = ghost ? IW'(2) : IW'(num);
        hs = vld && exp_ready;
        prev_hs = hs; prev_lane = sent;
        if (hs) begin
          sent++;
          if (sent == cnt) begin
            h_last = k;
            exp_done = k + 1 + (ZF ? N - cnt : 0);
          end
        end
        @(negedge clk);
      end
    end
    if (!ended) begin
      n_checks++; n_errors++;
      $display("FAIL timeout: load num=%0d never completed, got sent=%0d expected %0d", num, sent, cnt);
    end
    s_valid = 1'b0; start = 1'b0;
    check_lanes();
  endtask

  initial begin
    int nw, dc;
    tbl[0] = '{16, 0, 1'b1, 16, 17};
    tbl[1] = '{4, 1, 1'b0, ZF ? 16 : 4, ZF ? 20 : 8};
    tbl[2] = '{3, 0, 1'b0, ZF ? 16 : 3, ZF ? 17 : 4};
    tbl[3] = '{20, 0, 1'b0, 16, 17};
    tbl[4] = '{0, 0, 1'b0, ZF ? 16 : 0, ZF ? 17 : 1};
    tbl[5] = '{1, 0, 1'b0, ZF ? 16 : 1, ZF ? 17 : 2};
    for (int i = 0; i < N; i++) begin ref_lane[i] = '0; obs_lane[i] = '0; end

    reset = 1'b1; start = 1'b0; num_bias = '0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_w_en", 64'(w_en), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_s_ready", 64'(s_ready), 64'(0));
    chk("rst_w_index", 64'(w_index), 64'(0));
    chk("rst_w_data", 64'(w_data), 64'(0));
    reset = 1'b0;

    foreach (tbl[t]) begin
      run_load(tbl[t].num, tbl[t].vmode, tbl[t].seq, 1'b0, nw, dc);
      chk($sformatf("vec%0d_writes", t), 64'(nw), 64'(tbl[t].exp_wr));
      chk($sformatf("vec%0d_done_cycle", t), 64'(dc), 64'(tbl[t].exp_done));
    end

    // Reset after five of sixteen writes abandons the load.
    @(negedge clk);
    start = 1'b1; num_bias = IW'(16);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = W'(32'hA0 + i);
      @(negedge clk);
      chk("abort_w_en", 64'(w_en), 64'(N'(1) << i));
      chk("abort_w_data", 64'(w_data), 64'(32'hA0 + i));
      obs_lane[i] = w_data;
      ref_lane[i] = W'(32'hA0 + i);
    end
    s_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_w_en", 64'(w_en), 64'(0));
    chk("abort_rst_busy", 64'(busy), 64'(0));
    chk("abort_rst_done", 64'(done), 64'(0));
    chk("abort_rst_s_ready", 64'(s_ready), 64'(0));
    chk("abort_rst_w_index", 64'(w_index), 64'(0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_idle_done", 64'(done), 64'(0));
      chk("abort_idle_w_en", 64'(w_en), 64'(0));
      chk("abort_idle_busy", 64'(busy), 64'(0));
    end
    run_load(3, 0, 1'b0, 1'b0, nw, dc);
    chk("restart_writes", 64'(nw), 64'(ZF ? 16 : 3));

    // A start pulsed during LOAD must not disturb the count or lane index.
    run_load(8, 2, 1'b0, 1'b1, nw, dc);
    chk("ghost_writes", 64'(nw), 64'(ZF ? 16 : 8));

    for (int r = 0; r < 12; r++) begin
      int num;
      num = $urandom_range(0, 20);
      run_load(num, 2, 1'b0, 1'b0, nw, dc);
      chk($sformatf("rand%0d_writes", r), 64'(nw), 64'(ZF ? 16 : ((num > N) ? N : num)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
